// File: rtl/spi_frame_sender.sv
// SPI-style frame transmitter: walks a synchronous-read pixel RAM and serializes each pixel LSB-first on sck/sdi.
// Optional macro PIX_GAP_EN stretches NEXT by GAP_CYCLES idle cycles (sck=0, sdi=0) between pixels.
module spi_frame_sender #(
  parameter int CDEPTH       = 4,
  parameter int FRAME_ORDER  = 10,
  parameter int SCK_DIV_BITS = 3,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_ORDER-1:0] raddr,
  input  logic [3*CDEPTH-1:0]    rpix,
  output logic                   sck,
  output logic                   sdi
);

  localparam int PW  = 3 * CDEPTH;
  localparam int BCW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(PW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_BIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Current FSM state; left as a named signal so checkers can bind to it.
  state_t state;

  // Holds the not-yet-transmitted upper bits; the bit on the wire lives in sdi.
  logic [PW-2:0]           shreg;
  logic [BCW-1:0]          bcnt;
  logic [SCK_DIV_BITS-1:0] ph;
  logic [SCK_DIV_BITS-1:0] ph_inc;

  assign ph_inc = ph + 1'b1;

`ifdef PIX_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  logic [GW-1:0] gap_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      raddr <= '0;
      sck   <= 1'b0;
      sdi   <= 1'b0;
      shreg <= '0;
      bcnt  <= '0;
      ph    <= '0;
`ifdef PIX_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
            raddr <= '0;
          end
        end

        S_FETCH: begin
          state <= S_LOAD;
        end

        S_LOAD: begin
          shreg <= rpix[PW-1:1];
          sdi   <= rpix[0];
          bcnt  <= '0;
          ph    <= '0;
          state <= S_BIT;
        end

        S_BIT: begin
          ph  <= ph_inc;
          sck <= ph_inc[SCK_DIV_BITS-1];
          // End of the high half: present the next bit while sck returns low.
          if (&ph) begin
            sdi   <= shreg[0];
            shreg <= shreg >> 1;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == LAST_BIT) begin
              state <= S_NEXT;
              sck   <= 1'b0;
              sdi   <= 1'b0;
`ifdef PIX_GAP_EN
              gap_cnt <= '0;
`endif
            end
          end
        end

        S_NEXT: begin
`ifdef PIX_GAP_EN
          if (gap_cnt != GW'(GAP_CYCLES)) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            raddr <= raddr + 1'b1;
            if (&raddr) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
`else
          raddr <= raddr + 1'b1;
          if (&raddr) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          raddr <= '0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          sck   <= 1'b0;
          sdi   <= 1'b0;
          raddr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sender.sv
// Bench for spi_frame_sender: cycle model from frame/pixel/bit arithmetic, SPI receiver with expected-word queue.
module tb_spi_frame_sender;

  localparam int CD   = 4;
  localparam int FO   = 6;
  localparam int SDB  = 3;
  localparam int GAP  = 8;
  localparam int N    = 1 << FO;
  localparam int PW   = 3 * CD;
  localparam int H    = 1 << (SDB - 1);
`ifdef PIX_GAP_EN
  localparam int PIXP     = 3 + GAP + PW * 2 * H;
  localparam int DONE_LIT = 6849;
`else
  localparam int PIXP     = 3 + PW * 2 * H;
  localparam int DONE_LIT = 6337;
`endif
  localparam int FRAME_LEN = N * PIXP;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [FO-1:0] raddr;
  logic [PW-1:0] rpix;
  logic          sck;
  logic          sdi;

  spi_frame_sender #(
    .CDEPTH(CD), .FRAME_ORDER(FO), .SCK_DIV_BITS(SDB), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .raddr(raddr), .rpix(rpix), .sck(sck), .sdi(sdi)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RAM ----------------
  logic [PW-1:0] ram [N];
  always @(posedge clk) rpix <= ram[raddr];

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_bad   = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_done_cyc = 0;
  int mk = 0;
  bit chk_en = 0;
  bit rx_clear = 0;
  logic [PW-1:0] exp_q[$];

  int edges, words, done_seen;
  int hi_run, lo_run, hi_bad, lo_bad, sdi_chg;
  int rx_bits;
  logic [PW-1:0] rx_word;
  logic [PW-1:0] p3_bits;
  logic prev_sck, prev_sdi;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  // Expected {busy,done,sck,sdi,raddr} k cycles after start acceptance (k=0 means idle).
  function automatic logic [FO+3:0] model_out(int k);
    logic b, d, s, x;
    logic [FO-1:0] a;
    int p, o, bi, q;
    b = 0; d = 0; s = 0; x = 0; a = '0;
    if (k == FRAME_LEN + 1) begin
      b = 1; d = 1;
    end else if (k >= 1) begin
      p = (k - 1) / PIXP;
      o = (k - 1) % PIXP;
      b = 1;
      a = FO'(p);
      if (o >= 2 && o < 2 + PW * 2 * H) begin
        bi = (o - 2) / (2 * H);
        q  = (o - 2) % (2 * H);
        s  = (q >= H);
        x  = ram[p][bi];
      end
    end
    return {b, d, s, x, a};
  endfunction

  // Model advance: samples inputs on the same edge the DUT does.
  always @(posedge clk) begin
    if (reset) begin
      mk = 0;
      exp_q.delete();
      rx_clear = 1;
    end else if (mk == 0) begin
      if (start) begin
        mk = 1;
        accept_cyc = cyc;
        for (int i = 0; i < N; i++) exp_q.push_back(ram[i]);
        edges = 0; words = 0; hi_bad = 0; lo_bad = 0; sdi_chg = 0;
        p3_bits = '0;
      end
    end else if (mk == FRAME_LEN + 1) begin
      mk = 0;
    end else begin
      mk++;
    end
    cyc = cyc + 1;
  end

  // Compare + receiver, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_outputs", 32'({busy, done, sck, sdi, raddr}), 32'(model_out(mk)));

      if (rx_clear) begin
        rx_clear = 0; rx_bits = 0; rx_word = '0; hi_run = 0; lo_run = 0;
      end

      if (sck && !prev_sck) begin
        if (rx_bits != 0 && lo_run != H) lo_bad++;
        hi_run = 1; lo_run = 0;
        edges++;
        rx_word[rx_bits] = sdi;
        if (words == 3) p3_bits[rx_bits] = sdi;
        rx_bits++;
        if (rx_bits == PW) begin
          if (exp_q.size() == 0) check("rx_unexpected_word", 32'(rx_word), 32'hFFFF_FFFF);
          else check("rx_word", 32'(rx_word), 32'(exp_q.pop_front()));
          words++;
          rx_bits = 0;
          rx_word = '0;
        end
      end else if (sck) begin
        hi_run++;
      end else if (prev_sck) begin
        if (hi_run != H) hi_bad++;
        lo_run = 1; hi_run = 0;
      end else begin
        lo_run++;
      end
      if (sck && prev_sck && sdi != prev_sdi) sdi_chg++;
      prev_sck = sck;
      prev_sdi = sdi;

      if (done === 1'b1) begin
        done_seen++;
        check("done_cycle", 32'(cyc - accept_cyc), 32'(DONE_LIT));
        check("rise_edges", 32'(edges), 32'd768);
        check("words_rx", 32'(words), 32'd64);
        check("exp_left", 32'(exp_q.size()), 32'd0);
        check("sck_high_len", 32'(hi_bad), 32'd0);
        check("sck_low_len", 32'(lo_bad), 32'd0);
        check("sdi_chg_high", 32'(sdi_chg), 32'd0);
        check("pix3_sdi_seq", 32'(p3_bits), 32'h0000_0A5C);
        last_done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic goto_rel(input int n);
    int g = 0;
    while ((cyc - accept_cyc) < n && g < 10000) begin
      @(negedge clk);
      g++;
    end
    if ((cyc - accept_cyc) < n) check("goto_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) ram[i] = PW'((i * 7) % 4096);
    ram[3] = 12'hA5C;
    edges = 0; words = 0; done_seen = 0; hi_run = 0; lo_run = 0;
    hi_bad = 0; lo_bad = 0; sdi_chg = 0; rx_bits = 0; rx_word = '0;
    p3_bits = '0; prev_sck = 0; prev_sdi = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    check("reset_outputs", 32'({busy, done, sck, sdi, raddr}), 32'd0);

    repeat (50) @(negedge clk);
    check("idle_outputs", 32'({busy, done, sck, sdi, raddr}), 32'd0);

    // Frame 1: spurious starts while busy, then start held into a back-to-back frame.
    pulse_start();
    goto_rel(10);
    pulse_start();
    goto_rel(3000);
    pulse_start();
    goto_rel(6000);
    start = 1'b1;
    wait_done();
    @(negedge clk);
    @(negedge clk);
    check("b2b_accept_gap", 32'(accept_cyc - last_done_cyc), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_raddr", 32'(raddr), 32'd0);
    start = 1'b0;

    // Frame 2: reset in the middle of bit 5 of pixel 30.
    goto_rel(1 + 30 * PIXP + 2 + 5 * 2 * H + 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_outputs", 32'({busy, done, sck, sdi, raddr}), 32'd0);
    repeat (5) @(negedge clk);
    check("midreset_no_done", 32'(done_seen), 32'd1);

    // Frame 3: full frame from pixel 0 after the abort.
    pulse_start();
    wait_done();
    repeat (5) @(negedge clk);
    check("done_count", 32'(done_seen), 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
